// File: rtl/fp_result_buffer.sv
// fp_result_buffer: FIFO for floating-point adder results with exception flags; FP_RESULT_STICKY_FLAGS_EN adds sticky flags.
module fp_result_buffer #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int DEPTH          = 4,
  localparam int W             = EXP_WIDTH + MANTISSA_WIDTH + 1,
  localparam int AW            = $clog2(DEPTH),
  localparam int CW            = AW + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [W-1:0]  fpa_in,
  input  logic          overflow_in,
  input  logic          underflow_in,
  input  logic          valid_in,
  output logic          ready_out,
  output logic [W-1:0]  result_out,
  output logic          result_overflow_out,
  output logic          result_underflow_out,
  output logic          valid_out,
  input  logic          ready_in,
  output logic [CW-1:0] count_out,
  input  logic          clear_flags_in,
  output logic          sticky_overflow_out,
  output logic          sticky_underflow_out
);
  logic [W+1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  logic [W+1:0]  head;
  assign ready_out = count != CW'(DEPTH);
  assign valid_out = count != '0;
  assign push      = valid_in && ready_out;
  assign pop       = valid_out && ready_in;
  assign count_out = count;
  // Head fields are masked so an empty buffer presents an all-zero word.
  assign head                 = valid_out ? mem[rd_ptr] : '0;
  assign result_out           = head[W-1:0];
  assign result_overflow_out  = head[W];
  assign result_underflow_out = head[W+1];
  always_ff @(posedge clk_in)
    if (push) mem[wr_ptr] <= {underflow_in, overflow_in, fpa_in};
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
  end
`ifdef FP_RESULT_STICKY_FLAGS_EN
  logic sticky_ov, sticky_uf;
  // A flag set by this cycle's push overrides a coincident clear.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sticky_ov <= 1'b0;
      sticky_uf <= 1'b0;
    end else begin
      sticky_ov <= (push && overflow_in) || (sticky_ov && !clear_flags_in);
      sticky_uf <= (push && underflow_in) || (sticky_uf && !clear_flags_in);
    end
  end
  assign sticky_overflow_out  = sticky_ov;
  assign sticky_underflow_out = sticky_uf;
`else
  logic unused_clear;
  assign unused_clear         = clear_flags_in;
  assign sticky_overflow_out  = 1'b0;
  assign sticky_underflow_out = 1'b0;
`endif
endmodule

// File: tb/tb_fp_result_buffer.sv
// tb_fp_result_buffer: directed and random stimulus against a queue-based model of fp_result_buffer.
module tb_fp_result_buffer;
  localparam int DEPTH = 4;
  logic        clk_in = 1'b0;
  logic        rst_in, overflow_in, underflow_in, valid_in, ready_in, clear_flags_in;
  logic [31:0] fpa_in;
  logic        ready_out, result_overflow_out, result_underflow_out, valid_out;
  logic        sticky_overflow_out, sticky_underflow_out;
  logic [31:0] result_out;
  logic [2:0]  count_out;
  int passes = 0, total = 0;
  logic [33:0] q[$];
  logic m_so = 1'b0, m_su = 1'b0;

  fp_result_buffer #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .fpa_in(fpa_in), .overflow_in(overflow_in),
    .underflow_in(underflow_in), .valid_in(valid_in), .ready_out(ready_out),
    .result_out(result_out), .result_overflow_out(result_overflow_out),
    .result_underflow_out(result_underflow_out), .valid_out(valid_out),
    .ready_in(ready_in), .count_out(count_out), .clear_flags_in(clear_flags_in),
    .sticky_overflow_out(sticky_overflow_out), .sticky_underflow_out(sticky_underflow_out));

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [33:0] h;
    h = q.size() != 0 ? q[0] : 34'd0;
    chk({tag, ":count"}, 64'(count_out), 64'(q.size()));
    chk({tag, ":ready"}, 64'(ready_out), 64'(q.size() != DEPTH));
    chk({tag, ":valid"}, 64'(valid_out), 64'(q.size() != 0));
    chk({tag, ":result"}, 64'(result_out), 64'(h[31:0]));
    chk({tag, ":head_ov"}, 64'(result_overflow_out), 64'(h[32]));
    chk({tag, ":head_uf"}, 64'(result_underflow_out), 64'(h[33]));
    chk({tag, ":sticky_ov"}, 64'(sticky_overflow_out), 64'(m_so));
    chk({tag, ":sticky_uf"}, 64'(sticky_underflow_out), 64'(m_su));
  endtask

  // Drive one cycle, check outputs against the model's current contents, then advance the model.
  task automatic step(input string tag, input logic v, input logic [31:0] w, input logic of,
                      input logic uf, input logic rdy, input logic clr, input logic rst);
    bit do_push, do_pop;
    @(negedge clk_in);
    valid_in = v; fpa_in = w; overflow_in = of; underflow_in = uf;
    ready_in = rdy; clear_flags_in = clr; rst_in = rst;
    #1 check_all(tag);
    do_push = v && q.size() < DEPTH;
    do_pop  = rdy && q.size() > 0;
    @(posedge clk_in);
    if (rst) begin
      q.delete(); m_so = 1'b0; m_su = 1'b0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({uf, of, w});
`ifdef FP_RESULT_STICKY_FLAGS_EN
      m_so = (do_push && of) ? 1'b1 : clr ? 1'b0 : m_so;
      m_su = (do_push && uf) ? 1'b1 : clr ? 1'b0 : m_su;
`endif
    end
  endtask

  initial begin
    logic [31:0] fill [5];
    fill[0] = 32'h40000000; fill[1] = 32'h40400000; fill[2] = 32'h40800000;
    fill[3] = 32'h40A00000; fill[4] = 32'h40C00000;
    {valid_in, overflow_in, underflow_in, ready_in, clear_flags_in, fpa_in} = '0;
    rst_in = 1'b1;
    step("reset", 0, 0, 0, 0, 0, 0, 1);
    step("reset2", 1, 32'hDEADBEEF, 1, 1, 1, 1, 1);
    step("single_push", 1, 32'h3F800000, 0, 0, 0, 0, 0);
    step("single_head", 0, 0, 0, 0, 0, 0, 0);
    step("single_pop", 0, 0, 0, 0, 1, 0, 0);
    step("empty_pop", 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step("fill", 1, fill[i], 0, 0, 0, 0, 0);
    step("full_pop_no_push", 1, 32'h41000000, 0, 0, 1, 0, 0);
    step("full_refill", 1, 32'h41100000, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("drain", 0, 0, 0, 0, 1, 0, 0);
    step("conc_pre1", 1, 32'h3F000001, 0, 0, 0, 0, 0);
    step("conc_pre2", 1, 32'h3F000002, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("concurrent", 1, $urandom, 0, 0, 1, 0, 0);
    step("conc_after", 0, 0, 0, 0, 0, 0, 0);
    step("sticky_set", 1, 32'h7F800000, 1, 0, 1, 0, 0);
    step("sticky_set_clr", 1, 32'h7F800000, 1, 1, 1, 1, 0);
    step("sticky_clr", 0, 0, 0, 0, 0, 1, 0);
    step("sticky_chk", 0, 0, 0, 0, 1, 0, 0);
    step("flags_push", 1, 32'h12345678, 1, 1, 0, 0, 0);
    step("flags_head", 0, 0, 0, 0, 0, 0, 0);
    while (q.size() < 3) step("to3", 1, $urandom, 0, 0, 0, 0, 0);
    step("mid_reset", 1, 32'hCAFEF00D, 1, 1, 1, 1, 1);
    step("post_reset", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step("random", ($urandom % 4) != 0, $urandom, 1'($urandom), 1'($urandom),
           ($urandom % 3) == 0, ($urandom % 8) == 0, ($urandom % 97) == 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/fp_result_buffer.md
FP_RESULT_BUFFER -- requirements
Module: fp_result_buffer

Interface
REQ-001 The block SHALL have parameter EXP_WIDTH, default 8, giving the exponent field width of the adder result word.
REQ-002 The block SHALL have parameter MANTISSA_WIDTH, default 23, giving the mantissa field width; word width W = EXP_WIDTH+MANTISSA_WIDTH+1.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the entry count; legal values are powers of two, at least 2.
REQ-004 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port clk_in, input, 1 bit: the clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst_in, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port fpa_in, input, W bits: the sign/exponent/mantissa result word from the floating-point adder.
REQ-008 The block SHALL have ports overflow_in and underflow_in, input, 1 bit each: the adder exception flags for fpa_in.
REQ-009 The block SHALL have port valid_in, input, 1 bit: fpa_in and its flags are valid this cycle.
REQ-010 The block SHALL have port ready_out, output, 1 bit: the buffer can accept an entry this cycle.
REQ-011 The block SHALL have port result_out, output, W bits: the head-entry result word.
REQ-012 The block SHALL have ports result_overflow_out and result_underflow_out, output, 1 bit each: the head-entry flags.
REQ-013 The block SHALL have port valid_out, output, 1 bit: the head entry is valid.
REQ-014 The block SHALL have port ready_in, input, 1 bit: the consumer accepts the head entry.
REQ-015 The block SHALL have port count_out, output, clog2(DEPTH)+1 bits: the number of stored entries.
REQ-016 The block SHALL have port clear_flags_in, input, 1 bit: clears the sticky flags.
REQ-017 The block SHALL have ports sticky_overflow_out and sticky_underflow_out, output, 1 bit each: accumulated exception flags.

Function
REQ-018 Push SHALL occur when valid_in && ready_out; pop SHALL occur when valid_out && ready_in.
REQ-019 ready_out SHALL equal (count_out != DEPTH), be a function of registered state only, and not depend on ready_in.
REQ-020 valid_out SHALL equal (count_out != 0); there is no bypass, so a word pushed in cycle N appears at the output in cycle N+1 at the earliest.
REQ-021 result_out and the head flags SHALL be read combinationally from the head storage entry and SHALL be all zero when the buffer is empty.
REQ-022 Entries SHALL leave in push order (FIFO); write and read pointers SHALL wrap modulo DEPTH.
REQ-023 A simultaneous push and pop SHALL leave count_out unchanged, and both operations SHALL take effect.
REQ-024 When the buffer is full, valid_in SHALL be ignored and the input SHALL not be stored; a pop in the same cycle SHALL not enable a push that cycle.
REQ-025 A pop while empty SHALL be impossible by REQ-018, and ready_in SHALL be ignored.
REQ-026 Stored words SHALL be passed through bit-exact; the block SHALL perform no arithmetic on fpa_in.

Reset
REQ-027 While rst_in is high at a clock edge, pointers and count_out SHALL be reset to 0 and the sticky flags to 0. As a result, valid_out=0, ready_out=1, and result_out=0 in the following cycle.
REQ-028 Reset SHALL take priority over push, pop and clear in the same cycle, and it SHALL discard all stored entries mid-operation.

Configuration
REQ-029 With macro FP_RESULT_STICKY_FLAGS_EN defined, each sticky flag SHALL set on a push whose corresponding input flag is 1, and SHALL clear on clear_flags_in.
REQ-030 With FP_RESULT_STICKY_FLAGS_EN defined, if a set and a clear coincide, the set SHALL win.
REQ-031 Without FP_RESULT_STICKY_FLAGS_EN, sticky_overflow_out and sticky_underflow_out SHALL be tied to 0, clear_flags_in SHALL be ignored, and no sticky registers SHALL exist.

Verification
REQ-032 Single word: push fpa_in=0x3F800000 with ready_in=0 -> next cycle valid_out=1, result_out=0x3F800000, count_out=1.
REQ-033 Fill and stall: push 0x40000000, 0x40400000, 0x40800000, 0x40A00000 with ready_in=0 -> count_out=4 and ready_out=0. A fifth push of 0x40C00000 is dropped; the pop order is those four values.
REQ-034 Concurrent push/pop: at count_out=2, hold valid_in=1 and ready_in=1 for 5 cycles -> count_out stays 2 and output order matches input order, including across pointer wrap.
REQ-035 Sticky flags (macro defined): push with overflow_in=1 -> sticky_overflow_out=1. Assert clear_flags_in in the same cycle as another overflow push -> the flag stays 1. Clear alone -> the flag is 0.
REQ-036 Reset mid-operation: at count_out=3, assert rst_in one cycle -> next cycle count_out=0, valid_out=0, ready_out=1, result_out=0.
REQ-037 Macro undefined: push with overflow_in=1 and underflow_in=1 -> sticky outputs stay 0, while result_overflow_out=1 and result_underflow_out=1 at the head.
